// File: rtl/btn_conditioner.sv
// Paddle button front end: per-button synchroniser and debouncer, press pulses,
// and frame-aligned movement and start commands for the breakout game top level.

module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int CNT_W           = 18
) (
  input  logic pix_clk,
  input  logic reset_n,
  input  logic raw,
  output logic level,
  output logic press
);

  typedef enum logic {
    STABLE0 = 1'b0,
    STABLE1 = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             s1;
  logic             s2;
  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             rise;

  // Two-flop synchroniser; raw is never looked at anywhere else.
  always_ff @(posedge pix_clk or negedge reset_n) begin
    if (!reset_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= raw;
      s2 <= s1;
    end
  end

  always_ff @(posedge pix_clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= STABLE0;
      cnt   <= '0;
      press <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      press <= rise;
    end
  end

  // Any sample agreeing with the current level restarts the count from zero.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = '0;
    rise      = 1'b0;
    if (state_t'(s2) != state) begin
      if (cnt == CNT_LAST) begin
        state_nxt = state_t'(s2);
        rise      = s2;
      end else begin
        cnt_nxt = cnt + CNT_W'(1);
      end
    end
  end

  assign level = (state == STABLE1);

endmodule

module btn_conditioner #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int CNT_W           = 18
) (
  input  logic pix_clk,
  input  logic reset_n,
  input  logic btn_left_raw,
  input  logic btn_right_raw,
  input  logic frame,
  output logic btn_left,
  output logic btn_right,
  output logic left_press,
  output logic right_press,
  output logic move_left,
  output logic move_right,
  output logic start_req
);

  if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
    $error("DEBOUNCE_CYCLES must be at least 1");
  end
  if ((64'd1 << CNT_W) < 64'(DEBOUNCE_CYCLES)) begin : g_bad_cnt_w
    $error("CNT_W is too narrow to count DEBOUNCE_CYCLES");
  end

  logic pend;

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_left (
    .pix_clk(pix_clk),
    .reset_n(reset_n),
    .raw    (btn_left_raw),
    .level  (btn_left),
    .press  (left_press)
  );

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_right (
    .pix_clk(pix_clk),
    .reset_n(reset_n),
    .raw    (btn_right_raw),
    .level  (btn_right),
    .press  (right_press)
  );

  // A press landing on a frame edge is consumed by that frame, so pend is
  // cleared rather than set on frame edges.
  always_ff @(posedge pix_clk or negedge reset_n) begin
    if (!reset_n) begin
      move_left  <= 1'b0;
      move_right <= 1'b0;
      start_req  <= 1'b0;
      pend       <= 1'b0;
    end else if (frame) begin
      move_left  <= btn_left & ~btn_right;
      move_right <= btn_right & ~btn_left;
      start_req  <= pend | left_press | right_press;
      pend       <= 1'b0;
    end else begin
      start_req  <= 1'b0;
      pend       <= pend | left_press | right_press;
    end
  end

endmodule

// File: doc/btn_conditioner.md
# btn_conditioner

Conditions the two raw paddle buttons for the breakout game. It synchronises each button into `pix_clk`, debounces it, and produces clean levels and one-cycle press pulses. It also provides frame-aligned movement commands that stay stable for a whole frame. It sits directly upstream of the game top level: `move_left`/`move_right` drive paddle motion, and `start_req` drives the START→PLAY transition.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 250000: consecutive synchronised cycles a new level must persist before it is accepted. This is 10 ms at 25 MHz. Legal range is ≥ 1.
- `CNT_W`, default 18: debounce counter width. It must satisfy 2^CNT_W ≥ DEBOUNCE_CYCLES; elaboration fails otherwise.

Ports:
- `pix_clk` in 1: pixel clock, the only clock.
- `reset_n` in 1: reset, asynchronous assert, active-low.
- `btn_left_raw` in 1: raw asynchronous left button, active-high.
- `btn_right_raw` in 1: raw asynchronous right button, active-high.
- `frame` in 1: one-cycle strobe at the start of vertical blanking.
- `btn_left` out 1: debounced left level.
- `btn_right` out 1: debounced right level.
- `left_press` out 1: one-cycle pulse on a debounced left 0→1 transition.
- `right_press` out 1: one-cycle pulse on a debounced right 0→1 transition.
- `move_left` out 1: left command, updated only on `frame`.
- `move_right` out 1: right command, updated only on `frame`.
- `start_req` out 1: one-cycle pulse on a `frame` cycle if any press occurred since the previous `frame`.

## Operation
- **Synchroniser:** per button, two flops `s1`→`s2`, reset to 0. `btn_*_raw` is never used unsynchronised.
- **Debounce FSM:** one per button, states STABLE0 and STABLE1; the output level equals the state. The counter `cnt` is CNT_W bits, reset to 0.
  - `s2` == level: `cnt` ← 0.
  - `s2` ≠ level and `cnt` < DEBOUNCE_CYCLES−1: `cnt` ← `cnt`+1.
  - `s2` ≠ level and `cnt` == DEBOUNCE_CYCLES−1: level ← `s2` and `cnt` ← 0.
  - A glitch shorter than DEBOUNCE_CYCLES cycles never changes the level. Any return to the current level restarts the count from 0.
- **Press pulses:** `*_press` are registered and assert on the same edge the level goes 0→1. They deassert on the next edge. A 1→0 transition produces no pulse.
- **Frame latch:** on an edge with `frame`=1, the commands update from the pre-edge debounced levels:
  - `move_left` ← `btn_left` & ~`btn_right`.
  - `move_right` ← `btn_right` & ~`btn_left`.
  - Both held gives both 0; the two commands are never 1 together.
  - Between frames the commands hold their value regardless of button activity.
- **Start request:** a sticky `pend` flag is set by `left_press` or `right_press`.
  - On a `frame` edge, `start_req` ← `pend` | `left_press` | `right_press`, where the press terms are the pre-edge values. `pend` is cleared on the same edge.
  - A press pulse coincident with `frame` is consumed by that frame, not carried over to the next.
  - `start_req` is 0 on all non-frame edges.
- **Reset:** `reset_n`=0 asynchronously forces all of the following to 0: synchroniser flops, counters, `pend`, states (STABLE0), and every output. A debounce in progress is abandoned; no pulse is generated.

## Timing
- **Debounce latency:** call edge 0 the first edge that samples a new steady raw level into `s1`. `btn_*` (and `*_press`, for a rise) change at edge DEBOUNCE_CYCLES+1.
- **Command latency:** `move_*` change at the first `frame` edge strictly after the level change. `frame` coincident with the level-change edge uses the old level.
- **`start_req` latency:** asserts for exactly one cycle, at the first `frame` edge at or after the press pulse cycle.
- **Raw button held through reset release:** it is debounced from scratch; `*_press` fires at edge DEBOUNCE_CYCLES+1 after release.
- **Back-to-back `frame` strobes:** each is evaluated independently.
- **No combinational path:** none exists from any input to any output.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4.
1. Reset 0 with raw inputs toggling → all outputs 0. Release with raw stable 0 → outputs stay 0 for 20 cycles.
2. `btn_left_raw` steps 0→1 and holds → `btn_left`=1 and `left_press`=1 at edge 5, `left_press`=0 at edge 6. Raw steps back to 0 → `btn_left`=0 five edges later, with no pulse.
3. `btn_right_raw` bounces 1,1,1,0,1,1,1,0 (one per cycle) → `btn_right` stays 0. Raw then holds 1 → `btn_right`=1 exactly 5 edges after the last 0 is sampled.
4. Both buttons debounced high, then `frame` pulses → `move_left`=0 and `move_right`=0. Release right, debounce, `frame` → `move_left`=1. Both commands hold unchanged between frames.
5. Left press pulse at cycle 100, `frame` at 150 and at 200 → `start_req`=1 only at edge 150. A press coincident with a `frame` edge → `start_req`=1 on that edge, 0 on the next frame.
6. `reset_n` deasserted to 0 at cnt=2 of a rising debounce, then released with raw still 1 → no pulse during reset. `left_press` fires 5 edges after release.
